// File: rtl/rvv_backend_alu_rs.sv
// ALU reservation station: an in-order circular FIFO between dispatch and the
// ALU execution unit. Up to PUSH_N uops enter per cycle. The oldest uop is
// presented on uop_valid/uop_data, and the ALU consumes it with pop_rs.
// A one-cycle flush discards every entry.

module rvv_backend_alu_rs #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 256,
  parameter int PUSH_N = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PUSH_N-1:0]            push_valid,
  input  logic [PUSH_N*DATA_W-1:0]     push_data,
  output logic [PUSH_N-1:0]            push_ready,
  output logic                         uop_valid,
  output logic [DATA_W-1:0]            uop_data,
  input  logic                         pop_rs,
  input  logic                         flush,
  output logic [$clog2(DEPTH):0]       entry_count,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     free_s;
  logic [PUSH_N-1:0] accept_s;
  logic [CW-1:0]     n_push_s;
  logic              do_pop_s;

  // Free space is based on the registered count only. This keeps the
  // late-arriving pop_rs out of the push_ready timing path.
  assign free_s = CW'(DEPTH) - count_q;

  for (genvar g = 0; g < PUSH_N; g++) begin : g_ready
    assign push_ready[g] = (free_s > CW'(g));
  end

  assign accept_s  = push_valid & push_ready;
  assign do_pop_s  = pop_rs & uop_valid;

  // Head outputs come straight from state, so there is no push-to-head bypass.
  assign uop_valid   = (count_q != {CW{1'b0}});
  assign uop_data    = mem_q[rd_q];
  assign entry_count = count_q;
  assign full        = (count_q == CW'(DEPTH));

  // Count the accepted push lanes for this cycle.
  always_comb begin
    n_push_s = {CW{1'b0}};
    for (int i = 0; i < PUSH_N; i++) begin
      if (accept_s[i]) begin
        n_push_s = n_push_s + CW'(1);
      end else begin
        n_push_s = n_push_s;
      end
    end
  end

  // Next-state pointers and occupancy. Flush overrides any push or pop.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = {PW{1'b0}};
      wr_d    = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      rd_d    = rd_q + {{(PW-1){1'b0}}, do_pop_s};
      wr_d    = wr_q + n_push_s[PW-1:0];
      count_d = count_q + n_push_s - {{PW{1'b0}}, do_pop_s};
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= {PW{1'b0}};
      wr_q    <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Entry storage. It has no reset. Lane i lands at wr_ptr+i.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_N; i++) begin
      if (!flush && accept_s[i]) begin
        mem_q[wr_q + PW'(i)] <= push_data[i*DATA_W +: DATA_W];
      end
    end
  end

  rvv_backend_alu_rs_chk #(
    .DEPTH  (DEPTH),
    .PUSH_N (PUSH_N)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .pop_rs     (pop_rs),
    .uop_valid  (uop_valid),
    .rd_ptr     (rd_q),
    .wr_ptr     (wr_q),
    .count      (count_q)
  );

endmodule

// Protocol and consistency checks for the reservation station.
module rvv_backend_alu_rs_chk #(
  parameter int DEPTH  = 8,
  parameter int PUSH_N = 2
) (
  input logic                    clk,
  input logic                    rst,
  input logic [PUSH_N-1:0]       push_valid,
  input logic                    pop_rs,
  input logic                    uop_valid,
  input logic [$clog2(DEPTH)-1:0] rd_ptr,
  input logic [$clog2(DEPTH)-1:0] wr_ptr,
  input logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  // Push lanes must be contiguous from lane 0, so push_valid must have the form 0..01..1.
  a_contig: assert property (@(posedge clk) disable iff (rst)
    ((push_valid & (push_valid + PUSH_N'(1))) == {PUSH_N{1'b0}}))
    else $error("rs: non-contiguous push_valid %b", push_valid);

  // A pop against an empty station is ignored by the design. It is only reported here.
  a_pop_empty: assert property (@(posedge clk) disable iff (rst)
    !(pop_rs && !uop_valid))
    else $warning("rs: pop_rs while empty ignored");

  // Occupancy matches the pointer distance. At full, the pointers are equal and the distance is 0 mod DEPTH.
  a_count: assert property (@(posedge clk) disable iff (rst)
    ((wr_ptr - rd_ptr) == count[PW-1:0]) && (count <= (PW+1)'(DEPTH)))
    else $error("rs: count %0d inconsistent with pointers", count);

endmodule

// File: tb/tb_rvv_backend_alu_rs.sv
// Self-checking bench for rvv_backend_alu_rs (DEPTH=8, PUSH_N=2). It uses
// directed table vectors, hand-written wrap and reset sequences, and random
// traffic checked against a queue-based model.

module tb_rvv_backend_alu_rs;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 256;
  localparam int PUSH_N = 2;

  logic                     clk;
  logic                     rst;
  logic [PUSH_N-1:0]        push_valid;
  logic [PUSH_N*DATA_W-1:0] push_data;
  logic [PUSH_N-1:0]        push_ready;
  logic                     uop_valid;
  logic [DATA_W-1:0]        uop_data;
  logic                     pop_rs;
  logic                     flush;
  logic [3:0]               entry_count;
  logic                     full;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model_q [$];

  rvv_backend_alu_rs #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PUSH_N(PUSH_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .push_ready  (push_ready),
    .uop_valid   (uop_valid),
    .uop_data    (uop_data),
    .pop_rs      (pop_rs),
    .flush       (flush),
    .entry_count (entry_count),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pv;
    logic [7:0] t0;
    logic [7:0] t1;
    logic       pop;
    logic       fl;
    logic [3:0] exp_cnt;
    logic       exp_valid;
    logic [7:0] exp_head;
    logic [1:0] exp_ready;
  } vec_t;

  function automatic logic [DATA_W-1:0] mk(input logic [7:0] t);
    return {32{t}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply the current inputs for one cycle. Update the model, then check every output.
  task automatic step();
    int n;
    logic [1:0] rdy;
    n = model_q.size();
    for (int i = 0; i < 2; i++) rdy[i] = ((DEPTH - n) > i);
    if (flush) begin
      model_q.delete();
    end else begin
      if (pop_rs && n > 0) void'(model_q.pop_front());
      if (push_valid[0] && rdy[0]) model_q.push_back(push_data[0 +: DATA_W]);
      if (push_valid[1] && rdy[1]) model_q.push_back(push_data[DATA_W +: DATA_W]);
    end
    @(posedge clk);
    #1;
    n = model_q.size();
    for (int i = 0; i < 2; i++) rdy[i] = ((DEPTH - n) > i);
    chk("model_count", DATA_W'(entry_count), DATA_W'(n));
    chk("model_valid", DATA_W'(uop_valid), DATA_W'(n != 0));
    chk("model_full", DATA_W'(full), DATA_W'(n == DEPTH));
    chk("model_ready", DATA_W'(push_ready), DATA_W'(rdy));
    if (n != 0) chk("model_head", uop_data, model_q[0]);
  endtask

  task automatic drive(input logic [1:0] pv, input logic [7:0] t0, input logic [7:0] t1,
                       input logic pop, input logic fl);
    push_valid = pv;
    push_data  = {mk(t1), mk(t0)};
    pop_rs     = pop;
    flush      = fl;
  endtask

  vec_t vecs [20];

  initial begin
    // pv, t0, t1, pop, flush, exp_cnt, exp_valid, exp_head, exp_ready
    vecs[0]  = '{2'b11,  8'd1,  8'd2, 1'b0, 1'b0, 4'd2, 1'b1,  8'd1, 2'b11};
    vecs[1]  = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd1, 1'b1,  8'd2, 2'b11};
    vecs[2]  = '{2'b11,  8'd3,  8'd4, 1'b0, 1'b0, 4'd3, 1'b1,  8'd2, 2'b11};
    vecs[3]  = '{2'b11,  8'd5,  8'd6, 1'b0, 1'b0, 4'd5, 1'b1,  8'd2, 2'b11};
    vecs[4]  = '{2'b11,  8'd7,  8'd8, 1'b0, 1'b0, 4'd7, 1'b1,  8'd2, 2'b01};
    vecs[5]  = '{2'b11,  8'd9, 8'd10, 1'b0, 1'b0, 4'd8, 1'b1,  8'd2, 2'b00};
    vecs[6]  = '{2'b11, 8'd11, 8'd12, 1'b1, 1'b0, 4'd7, 1'b1,  8'd3, 2'b01};
    vecs[7]  = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd6, 1'b1,  8'd4, 2'b11};
    vecs[8]  = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd5, 1'b1,  8'd5, 2'b11};
    vecs[9]  = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd4, 1'b1,  8'd6, 2'b11};
    vecs[10] = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd3, 1'b1,  8'd7, 2'b11};
    vecs[11] = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd2, 1'b1,  8'd8, 2'b11};
    vecs[12] = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd1, 1'b1,  8'd9, 2'b11};
    vecs[13] = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd0, 1'b0,  8'd0, 2'b11};
    vecs[14] = '{2'b11, 8'd20, 8'd21, 1'b0, 1'b0, 4'd2, 1'b1, 8'd20, 2'b11};
    vecs[15] = '{2'b11, 8'd22, 8'd23, 1'b0, 1'b0, 4'd4, 1'b1, 8'd20, 2'b11};
    vecs[16] = '{2'b01, 8'd24,  8'd0, 1'b0, 1'b0, 4'd5, 1'b1, 8'd20, 2'b11};
    vecs[17] = '{2'b11, 8'd25, 8'd26, 1'b1, 1'b1, 4'd0, 1'b0,  8'd0, 2'b11};
    vecs[18] = '{2'b01, 8'd30,  8'd0, 1'b0, 1'b0, 4'd1, 1'b1, 8'd30, 2'b11};
    vecs[19] = '{2'b00,  8'd0,  8'd0, 1'b1, 1'b0, 4'd0, 1'b0,  8'd0, 2'b11};

    rst = 1'b1;
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", DATA_W'(uop_valid), DATA_W'(0));
    chk("reset_count", DATA_W'(entry_count), DATA_W'(0));
    chk("reset_full", DATA_W'(full), DATA_W'(0));
    chk("reset_ready", DATA_W'(push_ready), DATA_W'(2'b11));
    rst = 1'b0;

    // Directed table: push, pop, fill to full, partial lane accept, drain, flush.
    for (int v = 0; v < 20; v++) begin
      drive(vecs[v].pv, vecs[v].t0, vecs[v].t1, vecs[v].pop, vecs[v].fl);
      step();
      chk($sformatf("vec%0d_count", v), DATA_W'(entry_count), DATA_W'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d_valid", v), DATA_W'(uop_valid), DATA_W'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_ready", v), DATA_W'(push_ready), DATA_W'(vecs[v].exp_ready));
      if (vecs[v].exp_valid) chk($sformatf("vec%0d_head", v), uop_data, mk(vecs[v].exp_head));
    end

    // Wrap: 13 tagged uops pass through with the occupancy held at 3.
    drive(2'b11, 8'd0, 8'd1, 1'b0, 1'b0);
    step();
    drive(2'b01, 8'd2, 8'd0, 1'b0, 1'b0);
    step();
    for (int k = 3; k < 13; k++) begin
      chk($sformatf("wrap_order%0d", k - 3), uop_data, mk(8'(k - 3)));
      drive(2'b01, 8'(k), 8'd0, 1'b1, 1'b0);
      step();
      chk("wrap_occupancy", DATA_W'(entry_count), DATA_W'(3));
    end
    for (int k = 10; k < 13; k++) begin
      chk($sformatf("wrap_order%0d", k), uop_data, mk(8'(k)));
      drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
      step();
    end
    chk("wrap_empty", DATA_W'(uop_valid), DATA_W'(0));

    // Random legal traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      logic [1:0] pv;
      case ($urandom_range(0, 2))
        0:       pv = 2'b00;
        1:       pv = 2'b01;
        default: pv = 2'b11;
      endcase
      drive(pv, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0) & (model_q.size() != 0),
            1'($urandom_range(0, 39) == 0));
      step();
    end

    // Mid-stream asynchronous reset with four entries held.
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b1);
    step();
    drive(2'b11, 8'd40, 8'd41, 1'b0, 1'b0);
    step();
    drive(2'b11, 8'd42, 8'd43, 1'b0, 1'b0);
    step();
    chk("pre_rst_count", DATA_W'(entry_count), DATA_W'(4));
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    model_q.delete();
    #1;
    chk("async_rst_valid", DATA_W'(uop_valid), DATA_W'(0));
    chk("async_rst_count", DATA_W'(entry_count), DATA_W'(0));
    chk("async_rst_ready", DATA_W'(push_ready), DATA_W'(2'b11));
    chk("async_rst_full", DATA_W'(full), DATA_W'(0));
    #1;
    rst = 1'b0;
    drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    step();
    chk("pop_empty_count", DATA_W'(entry_count), DATA_W'(0));
    drive(2'b01, 8'd50, 8'd0, 1'b0, 1'b0);
    step();
    chk("post_rst_head", uop_data, mk(8'd50));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
